oflow_frame_buf_resp: RTL

OFLOW_FRAME_BUF_RESP -- requirements
Module: oflow_frame_buf_resp

---
 rtl/oflow_frame_buf_resp.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/oflow_frame_buf_resp.sv
// rtl/oflow_frame_buf_resp.sv - ping-pong frame buffer: writes fill one SRAM bank while reads replay the other
// A read requested together with a write is held pending and replays the bank just written.
module oflow_frame_buf_resp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              start_write,
  input  logic              start_read,
  input  logic [ADDR_W:0]   num_entries,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done_write,
  output logic              done_read,
  output logic              busy,
  output logic              err_overlap,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;

  state_t            state;
  logic              wr_bank;
  logic              pending;
  logic [ADDR_W:0]   prev_count;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W:0]   wr_len;
  logic              last;
  logic              start_any;

  assign wr_len    = (num_entries > DEPTH) ? DEPTH : num_entries;
  assign last      = ({1'b0, cnt} == (len - 1'b1));
  assign start_any = start_write | start_read;

  assign busy      = (state != IDLE) | pending;
  assign mem_wdata = wr_ready ? wr_data : '0;
  assign rd_data   = rd_valid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state       <= IDLE;
      wr_bank     <= 1'b0;
      pending     <= 1'b0;
      prev_count  <= '0;
      len         <= '0;
      cnt         <= '0;
      err_overlap <= 1'b0;
      wr_ready    <= 1'b0;
      rd_valid    <= 1'b0;
      done_write  <= 1'b0;
      done_read   <= 1'b0;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
    end else begin
      done_write <= 1'b0;
      done_read  <= 1'b0;
      case (state)
        IDLE: begin
          // A pending read behaves like a start_read arriving in the done_write cycle
          if (pending || (start_read && !start_write)) begin
            if (pending) begin
              pending <= 1'b0;
              if (start_any) err_overlap <= 1'b1;
            end
            if (prev_count == '0) begin
              done_read <= 1'b1;
            end else begin
              state    <= READ;
              len      <= prev_count;
              cnt      <= '0;
              mem_cs   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {~wr_bank, {ADDR_W{1'b0}}};
            end
          end else if (start_write) begin
            if (start_read) pending <= 1'b1;
            if (wr_len == '0) begin
              done_write <= 1'b1;
              wr_bank    <= ~wr_bank;
              prev_count <= '0;
            end else begin
              state    <= WRITE;
              len      <= wr_len;
              cnt      <= '0;
              wr_ready <= 1'b1;
              mem_cs   <= 1'b1;
              mem_we   <= 1'b1;
              mem_addr <= {wr_bank, {ADDR_W{1'b0}}};
            end
          end
        end
        WRITE: begin
          if (start_any) err_overlap <= 1'b1;
          if (last) begin
            state      <= IDLE;
            wr_ready   <= 1'b0;
            mem_cs     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            done_write <= 1'b1;
            wr_bank    <= ~wr_bank;
            prev_count <= len;
          end else begin
            cnt      <= cnt + 1'b1;
            mem_addr <= {wr_bank, cnt + 1'b1};
          end
        end
        READ: begin
          if (start_any) err_overlap <= 1'b1;
          rd_valid <= 1'b1;
          if (last) begin
            state     <= READ_DRAIN;
            mem_cs    <= 1'b0;
            mem_addr  <= '0;
            done_read <= 1'b1;
          end else begin
            cnt      <= cnt + 1'b1;
            mem_addr <= {~wr_bank, cnt + 1'b1};
          end
        end
        READ_DRAIN: begin
          if (start_any) err_overlap <= 1'b1;
          rd_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
